timer: RTL and testbench
========================

# timer

Memory-mapped DIV/TIMA/TMA/TAC timer peripheral for the Game Boy CPU core. It sits on the external bus beside `mem`, sharing `addr_ext`, `data_ext`, `mem_we` and `mem_re`. It raises a one-cycle timer interrupt request that the system top ORs into bit 2 of the CPU's `IF_in`, together with a matching `IF_load`. It is the interrupt source directly upstream of the CPU's IF register.

## Interface

- `BASE_ADDR`, default 16'hFF04: address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.
- `clock`  in  1: single system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state while low.
- `addr_ext`  in  16: bus address.
- `data_ext`  inout  8: bus data; driven only during a decoded read, high-Z otherwise.
- `mem_we`  in  1: bus write strobe, sampled on the rising edge.
- `mem_re`  in  1: bus read strobe.
- `timer_irq`  out  1: one-cycle interrupt request pulse on TIMA overflow.
- `div_count`  out  16: internal system counter, for debug and bench visibility.

## Operation

- State:
  - `cnt[15:0]`, the system counter.
  - TIMA[7:0], TMA[7:0], TAC[2:0].
  - `sig_q`, the previous edge-detect sample.
  - `timer_irq` register.
- Reset (reset low, asynchronous):
  - cnt, TIMA, TMA, TAC, `sig_q` and `timer_irq` go to 0.
  - `data_ext` goes high-Z.
- cnt increments by 1 every clock and wraps 16'hFFFF to 0. DIV reads as cnt[15:8].
- Selected bit, by TAC[1:0]:
  - 00 selects cnt[9].
  - 01 selects cnt[3].
  - 10 selects cnt[5].
  - 11 selects cnt[7].
- Edge detect:
  - sig = TAC[2] & cnt[sel], combinational.
  - tick = sig_q & ~sig.
  - sig_q <= sig every clock.
- Timer tick: on an edge where tick=1, TIMA <= TIMA+1 (8-bit).
- Overflow: on a tick edge with TIMA=8'hFF:
  - TIMA <= TMA.
  - timer_irq <= 1.
- timer_irq is 0 on every other edge, so it is a pulse exactly one cycle wide.
- Writes (mem_we=1 and address hit) take effect at the rising edge:
  - DIV write: cnt <= 0 and the data is ignored. If the selected bit was 1, the resulting falling sig produces a tick on the next edge (intended hardware quirk).
  - TIMA write: TIMA <= data. This has priority over increment and overflow reload in the same edge, and no irq is raised.
  - TMA write: TMA <= data. On an overflow in the same edge, TIMA reloads with the newly written data.
  - TAC write: TAC <= data[2:0]. Clearing TAC[2] or changing the select while sig=1 yields a tick (same quirk).
- Reads (mem_re=1, mem_we=0, address hit) drive data_ext combinationally:
  - DIV: cnt[15:8].
  - TIMA: TIMA.
  - TMA: TMA.
  - TAC: {5'b11111, TAC}.
- Addresses outside BASE_ADDR..BASE_ADDR+3 are ignored for writes and leave `data_ext` high-Z for reads.
- mem_we and mem_re both high: the write is performed and the bus is not driven.

## Timing

- Read latency 0: data is valid in the same cycle as `mem_re`.
- Write latency 1: the new value is visible to reads in the cycle after the write edge.
- Tick latency: TIMA increments on the edge after the one where cnt[sel] fell. Example with TAC=3'b101 (enabled, select cnt[3]):
  - cnt goes 0x0F to 0x10 at edge k.
  - TIMA increments at edge k+1.
  - Steady-state period is 16 clocks.
- Overflow: the TIMA reload and the timer_irq rise occur at the same edge. timer_irq falls at the next edge.
- Reset asserted mid-operation: all state clears immediately. After reset deasserts, cnt restarts at 0 on the first rising edge.

## Test plan

- Reset: assert reset low for 3 clocks, then read FF04..FF07 -> 00, 00, 00, F8; timer_irq=0; data_ext is Z when not reading.
- Increment rate: write TAC=05, TIMA=00, then run 160 clocks -> TIMA advances by exactly 10 with 16-clock spacing; TAC=04 -> one increment per 1024 clocks.
- Overflow: TMA=AB, TIMA=FF, TAC=05 -> at the next tick TIMA=AB and timer_irq is high for exactly one cycle; no further pulse until the next overflow.
- DIV-reset quirk: TAC=04, let cnt reach 0x0200 (bit 9 set), write DIV -> cnt=0 and TIMA increments once on the following edge; DIV reads 00.
- Collisions:
  - TIMA write of 0x42 on a tick edge with TIMA=FF -> TIMA=42 and no irq.
  - TMA write of 0x11 on an overflow edge -> TIMA=11.
- Async reset mid-count: assert reset while TIMA=7F and cnt=0x1234 -> all state reads 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/timer_if.sv
// Bus-side control signals shared by the timer and the other external-bus
// peripherals: address plus write/read strobes. The tristate data byte stays
// a plain inout port on the peripheral so its drive can be resolved on a net.
interface timer_if;
  logic [15:0] addr_ext;
  logic        mem_we;
  logic        mem_re;

  modport master (output addr_ext, output mem_we, output mem_re);
  modport slave  (input  addr_ext, input  mem_we, input  mem_re);
endinterface

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer peripheral. A free-running 16-bit counter feeds a
// falling-edge detector on a TAC-selected bit; each detected fall bumps TIMA,
// and a TIMA overflow reloads from TMA and fires a one-cycle interrupt pulse.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clock,
  input  logic        reset,
  timer_if.slave      bus,
  inout  wire  [7:0]  data_ext,
  output logic        timer_irq,
  output logic [15:0] div_count
);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        sig_q, sig_d;
  logic        irq_q, irq_d;

  logic [15:0] off;
  logic        hit;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic        rd_en;
  logic [7:0]  rdata;
  logic [7:0]  wdata;
  logic        sel_bit;
  logic        sig;
  logic        tick;

  // Register decode is relative to BASE_ADDR so unaligned bases still work.
  assign off     = bus.addr_ext - BASE_ADDR;
  assign hit     = (off[15:2] == 14'd0);
  assign wdata   = data_ext;
  assign wr_div  = bus.mem_we & hit & (off[1:0] == 2'd0);
  assign wr_tima = bus.mem_we & hit & (off[1:0] == 2'd1);
  assign wr_tma  = bus.mem_we & hit & (off[1:0] == 2'd2);
  assign wr_tac  = bus.mem_we & hit & (off[1:0] == 2'd3);
  // A simultaneous write wins; the bus is left undriven in that case.
  assign rd_en   = bus.mem_re & ~bus.mem_we & hit;

  // Counter-bit select and falling-edge detect feeding the TIMA increment.
  always_comb begin
    sel_bit = 1'b0;
    case (tac_q[1:0])
      2'b00:   sel_bit = cnt_q[9];
      2'b01:   sel_bit = cnt_q[3];
      2'b10:   sel_bit = cnt_q[5];
      default: sel_bit = cnt_q[7];
    endcase
    sig  = tac_q[2] & sel_bit;
    tick = sig_q & ~sig;
  end

  // Next-state: counter, reload/increment with write priority, irq pulse.
  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    tma_d  = tma_q;
    tac_d  = tac_q;
    tima_d = tima_q;
    irq_d  = 1'b0;
    sig_d  = sig;
    if (wr_div) cnt_d = 16'd0;
    if (wr_tma) tma_d = wdata;
    if (wr_tac) tac_d = wdata[2:0];
    if (tick) begin
      if (tima_q == 8'hFF) begin
        // Reload uses tma_d so a same-edge TMA write is picked up.
        tima_d = tma_d;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
    // A CPU write to TIMA overrides both increment and overflow reload.
    if (wr_tima) begin
      tima_d = wdata;
      irq_d  = 1'b0;
    end
  end

  // State registers, cleared asynchronously while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 16'd0;
      tima_q <= 8'd0;
      tma_q  <= 8'd0;
      tac_q  <= 3'd0;
      sig_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
      sig_q  <= sig_d;
      irq_q  <= irq_d;
    end
  end

  // Read mux; unused TAC bits read back as ones.
  always_comb begin
    rdata = 8'h00;
    case (off[1:0])
      2'd0:    rdata = cnt_q[15:8];
      2'd1:    rdata = tima_q;
      2'd2:    rdata = tma_q;
      default: rdata = {5'b11111, tac_q};
    endcase
  end

  assign data_ext  = rd_en ? rdata : 8'bzzzz_zzzz;
  assign timer_irq = irq_q;
  assign div_count = cnt_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the timer peripheral. Inputs change and outputs are
// sampled on the falling clock edge; expected values are worked out by hand
// from the counter position at each step.
module tb_timer;

  logic        clock;
  logic        reset;
  wire  [7:0]  data_ext;
  logic        timer_irq;
  logic [15:0] div_count;
  logic [7:0]  tb_data;
  logic        tb_drv;
  logic [7:0]  rd;
  int          checks;
  int          failures;

  timer_if bus ();

  assign data_ext = tb_drv ? tb_data : 8'bzzzz_zzzz;

  timer #(.BASE_ADDR(16'hFF04)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .data_ext  (data_ext),
    .timer_irq (timer_irq),
    .div_count (div_count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr_ext = a;
    tb_data      = d;
    tb_drv       = 1'b1;
    bus.mem_we   = 1'b1;
    @(negedge clock);
    bus.mem_we   = 1'b0;
    tb_drv       = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus.addr_ext = a;
    bus.mem_re   = 1'b1;
    #1;
    d            = data_ext;
    bus.mem_re   = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    tb_drv       = 1'b0;
    tb_data      = 8'h00;
    bus.addr_ext = 16'h0000;
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;

    // Reset held for 3 clocks.
    tick_n(3);
    check("rst_cnt", div_count, 16'h0000);
    check("rst_irq", {15'd0, timer_irq}, 16'h0000);
    reset = 1'b1;
    bus_read(16'hFF04, rd); check("rst_div",  {8'd0, rd}, 16'h0000);
    bus_read(16'hFF05, rd); check("rst_tima", {8'd0, rd}, 16'h0000);
    bus_read(16'hFF06, rd); check("rst_tma",  {8'd0, rd}, 16'h0000);
    bus_read(16'hFF07, rd); check("rst_tac",  {8'd0, rd}, 16'h00F8);
    // Bus must be left to the bench when not reading or out of range.
    tb_drv = 1'b1; tb_data = 8'h00; bus.addr_ext = 16'hFF07; #1;
    check("idle_bus", {8'd0, data_ext}, 16'h0000);
    bus.addr_ext = 16'hFF08; bus.mem_re = 1'b1; #1;
    check("oor_hi_bus", {8'd0, data_ext}, 16'h0000);
    bus.addr_ext = 16'hFF03; #1;
    check("oor_lo_bus", {8'd0, data_ext}, 16'h0000);
    bus.mem_re = 1'b0; tb_drv = 1'b0;
    tick_n(1);
    check("cnt_first", div_count, 16'h0001);

    // Increment rate, TAC=05: ticks land on cnt=0x11,0x21,...
    bus_write(16'hFF04, 8'h5A);
    check("div_wr_cnt", div_count, 16'h0000);
    bus_write(16'hFF07, 8'h05);
    bus_write(16'hFF05, 8'h00);
    tick_n(14);
    check("r5_cnt10", div_count, 16'h0010);
    bus_read(16'hFF05, rd); check("r5_t0", {8'd0, rd}, 16'h0000);
    tick_n(1);
    bus_read(16'hFF05, rd); check("r5_t1", {8'd0, rd}, 16'h0001);
    tick_n(15);
    bus_read(16'hFF05, rd); check("r5_t1_hold", {8'd0, rd}, 16'h0001);
    tick_n(1);
    bus_read(16'hFF05, rd); check("r5_t2", {8'd0, rd}, 16'h0002);
    tick_n(129);
    check("r5_cnt_end", div_count, 16'h00A2);
    bus_read(16'hFF05, rd); check("r5_t10", {8'd0, rd}, 16'h000A);

    // Increment rate, TAC=04: one tick per 1024 clocks.
    bus_write(16'hFF07, 8'h04);
    bus_write(16'hFF05, 8'h00);
    bus_read(16'hFF07, rd); check("tac04_rd", {8'd0, rd}, 16'h00FC);
    tick_n(860);
    check("r4_cnt400", div_count, 16'h0400);
    bus_read(16'hFF05, rd); check("r4_t0", {8'd0, rd}, 16'h0000);
    tick_n(1);
    bus_read(16'hFF05, rd); check("r4_t1", {8'd0, rd}, 16'h0001);
    tick_n(1023);
    bus_read(16'hFF05, rd); check("r4_t1_hold", {8'd0, rd}, 16'h0001);
    tick_n(1);
    bus_read(16'hFF05, rd); check("r4_t2", {8'd0, rd}, 16'h0002);

    // Overflow with TMA reload and a single irq pulse.
    bus_write(16'hFF06, 8'hAB);
    bus_write(16'hFF05, 8'hFF);
    bus_write(16'hFF07, 8'h05);
    check("ov_cnt", div_count, 16'h0804);
    tick_n(12);
    bus_read(16'hFF05, rd); check("ov_pre_tima", {8'd0, rd}, 16'h00FF);
    check("ov_pre_irq", {15'd0, timer_irq}, 16'h0000);
    tick_n(1);
    bus_read(16'hFF05, rd); check("ov_tima", {8'd0, rd}, 16'h00AB);
    check("ov_irq", {15'd0, timer_irq}, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      tick_n(1);
      check("ov_irq_low", {15'd0, timer_irq}, 16'h0000);
    end
    bus_read(16'hFF05, rd); check("ov_next_tick", {8'd0, rd}, 16'h00AC);

    // DIV write while selected bit (cnt[9]) is high produces one tick.
    bus_write(16'hFF07, 8'h04);
    bus_write(16'hFF04, 8'h00);
    bus_write(16'hFF05, 8'h10);
    tick_n(511);
    check("dq_cnt200", div_count, 16'h0200);
    bus_write(16'hFF04, 8'hFF);
    check("dq_cnt0", div_count, 16'h0000);
    bus_read(16'hFF04, rd); check("dq_div", {8'd0, rd}, 16'h0000);
    bus_read(16'hFF05, rd); check("dq_tima_pre", {8'd0, rd}, 16'h0010);
    tick_n(1);
    bus_read(16'hFF05, rd); check("dq_tima", {8'd0, rd}, 16'h0011);
    check("dq_cnt1", div_count, 16'h0001);

    // TIMA write on an overflowing tick edge: write wins, no irq.
    bus_write(16'hFF07, 8'h05);
    bus_write(16'hFF05, 8'hFF);
    tick_n(13);
    check("c1_cnt", div_count, 16'h0010);
    bus_write(16'hFF05, 8'h42);
    bus_read(16'hFF05, rd); check("c1_tima", {8'd0, rd}, 16'h0042);
    check("c1_irq", {15'd0, timer_irq}, 16'h0000);

    // TMA write on an overflow edge: reload takes the new value.
    bus_write(16'hFF05, 8'hFF);
    tick_n(14);
    check("c2_cnt", div_count, 16'h0020);
    bus_write(16'hFF06, 8'h11);
    bus_read(16'hFF05, rd); check("c2_tima", {8'd0, rd}, 16'h0011);
    bus_read(16'hFF06, rd); check("c2_tma",  {8'd0, rd}, 16'h0011);
    check("c2_irq", {15'd0, timer_irq}, 16'h0001);
    tick_n(1);
    check("c2_irq_fall", {15'd0, timer_irq}, 16'h0000);

    // Write and read strobes together: write happens, bus not driven.
    bus.addr_ext = 16'hFF07; tb_data = 8'h04; tb_drv = 1'b1;
    bus.mem_we = 1'b1; bus.mem_re = 1'b1; #1;
    check("wr_rd_bus", {8'd0, data_ext}, 16'h0004);
    @(negedge clock);
    bus.mem_we = 1'b0; bus.mem_re = 1'b0; tb_drv = 1'b0;
    bus_read(16'hFF07, rd); check("wr_rd_tac", {8'd0, rd}, 16'h00FC);

    // Async reset mid-count.
    bus_write(16'hFF07, 8'h00);
    bus_write(16'hFF04, 8'h00);
    bus_write(16'hFF05, 8'h7F);
    tick_n(16'h1233);
    check("ar_cnt_pre", div_count, 16'h1234);
    bus_read(16'hFF05, rd); check("ar_tima_pre", {8'd0, rd}, 16'h007F);
    reset = 1'b0; #1;
    check("ar_cnt", div_count, 16'h0000);
    check("ar_irq", {15'd0, timer_irq}, 16'h0000);
    bus_read(16'hFF05, rd); check("ar_tima", {8'd0, rd}, 16'h0000);
    bus_read(16'hFF06, rd); check("ar_tma",  {8'd0, rd}, 16'h0000);
    bus_read(16'hFF07, rd); check("ar_tac",  {8'd0, rd}, 16'h00F8);
    tick_n(2);
    reset = 1'b1;
    tick_n(1);
    check("ar_restart", div_count, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
